// File: rtl/noc_router_buffered_pkg.sv
// Shared NoC definitions: port indices, packet width and coordinate field positions.
package pa_noc;

   localparam int APB_PACKET_WIDTH = 32;
   localparam int N_PORTS          = 5;

   typedef enum logic [2:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      SOUTH = 3'd2,
      EAST  = 3'd3,
      WEST  = 3'd4
   } port_t;

   typedef enum logic {
      FIELD_COL = 1'b0,
      FIELD_ROW = 1'b1
   } coord_field_t;

   // Column sits in the lowest bits of the packet, row directly above it.
   function automatic int coord_lsb(coord_field_t field, int coord_width);
      return (field == FIELD_ROW) ? coord_width : 0;
   endfunction

endpackage

// File: rtl/noc_router_buffered_fifo.sv
// Input FIFO with a registered head, one extra pointer bit distinguishes full from empty.
module noc_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] rd_data
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = mem[rd_ptr[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage carries no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/noc_router_buffered.sv
// Five-port XY mesh router with per-input FIFOs and per-output round-robin arbitration.
module noc_router_buffered
   import pa_noc::*;
#(
   parameter  int GRID_WIDTH   = 4,
   parameter  int ROUTER_ROW   = 0,
   parameter  int ROUTER_COL   = 0,
   parameter  int FIFO_DEPTH   = 4,
   localparam int PACKET_WIDTH = APB_PACKET_WIDTH
) (
   input  logic                                  i_clk,
   input  logic                                  i_srst,
   input  logic [N_PORTS-1:0][PACKET_WIDTH-1:0]  i_inPacket,
   input  logic [N_PORTS-1:0]                    i_inValid,
   output logic [N_PORTS-1:0]                    o_inReady,
   output logic [N_PORTS-1:0][PACKET_WIDTH-1:0]  o_outPacket,
   output logic [N_PORTS-1:0]                    o_outValid,
   input  logic [N_PORTS-1:0]                    i_outReady,
   output logic                                  o_drop
);

   localparam int COORD_WIDTH = $clog2(GRID_WIDTH);
   localparam int COL_LSB     = coord_lsb(FIELD_COL, COORD_WIDTH);
   localparam int ROW_LSB     = coord_lsb(FIELD_ROW, COORD_WIDTH);

   logic [N_PORTS-1:0]      full;
   logic [N_PORTS-1:0]      empty;
   logic [N_PORTS-1:0]      push;
   logic [N_PORTS-1:0]      pop;
   logic [N_PORTS-1:0]      oom;
   logic [PACKET_WIDTH-1:0] head  [N_PORTS];
   port_t                   route [N_PORTS];
   logic [N_PORTS-1:0]      gnt   [N_PORTS];

   assign o_inReady = ~full & {N_PORTS{~i_srst}};
   assign push      = i_inValid & o_inReady;

   for (genvar i = 0; i < N_PORTS; i++) begin : g_in
      logic [COORD_WIDTH-1:0] dcol;
      logic [COORD_WIDTH-1:0] drow;
      port_t                  dir;

      noc_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PACKET_WIDTH)) u_fifo (
         .clk     (i_clk),
         .rst     (i_srst),
         .push    (push[i]),
         .pop     (pop[i]),
         .wr_data (i_inPacket[i]),
         .full    (full[i]),
         .empty   (empty[i]),
         .rd_data (head[i])
      );

      assign dcol = head[i][COL_LSB +: COORD_WIDTH];
      assign drow = head[i][ROW_LSB +: COORD_WIDTH];

      // Leaving through the east or south edge implies a destination beyond the grid,
      // so the coordinate bound alone covers every out-of-mesh case.
      assign oom[i] = !empty[i] && ((int'(dcol) >= GRID_WIDTH) || (int'(drow) >= GRID_WIDTH));

      always_comb begin
         dir = LOCAL;
         if (int'(dcol) > ROUTER_COL)      dir = EAST;
         else if (int'(dcol) < ROUTER_COL) dir = WEST;
         else if (int'(drow) > ROUTER_ROW) dir = SOUTH;
         else if (int'(drow) < ROUTER_ROW) dir = NORTH;
      end

      assign route[i] = dir;
   end

   always_comb begin
      pop = oom;
      for (int o = 0; o < N_PORTS; o++) pop = pop | gnt[o];
   end

   for (genvar o = 0; o < N_PORTS; o++) begin : g_out
      logic [N_PORTS-1:0]      req;
      logic [2:0]              ptr;
      logic [2:0]              sel_idx;
      logic                    found;
      logic                    load;
      logic                    vld_q;
      logic [PACKET_WIDTH-1:0] pkt_q;

      always_comb begin
         req = '0;
         for (int i = 0; i < N_PORTS; i++)
            req[i] = !empty[i] && !oom[i] && (route[i] == port_t'(o));
         found   = 1'b0;
         sel_idx = ptr;
         for (int k = 0; k < N_PORTS; k++) begin
            if (!found && req[(int'(ptr) + k) % N_PORTS]) begin
               found   = 1'b1;
               sel_idx = 3'((int'(ptr) + k) % N_PORTS);
            end
         end
         load = !vld_q || i_outReady[o];
      end

      assign gnt[o] = (found && load) ? (N_PORTS'(1) << sel_idx) : '0;

      always_ff @(posedge i_clk) begin
         if (i_srst) begin
            vld_q <= 1'b0;
            pkt_q <= '0;
            ptr   <= '0;
         end else if (load) begin
            vld_q <= found;
            if (found) begin
               pkt_q <= head[sel_idx];
               ptr   <= (sel_idx == 3'(N_PORTS - 1)) ? 3'd0 : sel_idx + 3'd1;
            end
         end
      end

      assign o_outValid[o]  = vld_q;
      assign o_outPacket[o] = pkt_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_srst) o_drop <= 1'b0;
      else        o_drop <= |oom;
   end

endmodule

// File: tb/tb_noc_router_buffered.sv
// Directed and randomized checks of the buffered XY router against a queue-based reference.
module tb_noc_router_buffered;
   import pa_noc::*;

   localparam int NP = 5;

   logic                clk = 1'b0;
   logic                srst;
   logic [NP-1:0][31:0] in_pkt;
   logic [NP-1:0]       in_vld;
   logic [NP-1:0]       in_rdy;
   logic [NP-1:0][31:0] out_pkt;
   logic [NP-1:0]       out_vld;
   logic [NP-1:0]       out_rdy;
   logic                drop;

   noc_router_buffered #(
      .GRID_WIDTH (4),
      .ROUTER_ROW (1),
      .ROUTER_COL (1),
      .FIFO_DEPTH (4)
   ) dut (
      .i_clk       (clk),
      .i_srst      (srst),
      .i_inPacket  (in_pkt),
      .i_inValid   (in_vld),
      .o_inReady   (in_rdy),
      .o_outPacket (out_pkt),
      .o_outValid  (out_vld),
      .i_outReady  (out_rdy),
      .o_drop      (drop)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int                  checks   = 0;
   int                  failures = 0;
   logic [31:0]         expq [NP*NP][$];
   logic [NP-1:0]       stall_prev = '0;
   logic [31:0]         hold_pkt [NP];
   logic [NP-1:0]       obs_vld;
   logic [NP-1:0]       obs_rdy;
   logic [NP-1:0][31:0] obs_pkt;
   logic                obs_drop;

   // Packet: {sequence[23:0], source[3:0], row[1:0], col[1:0]}
   function automatic logic [31:0] mk(int src, int seq, int row, int col);
      return {seq[23:0], src[3:0], row[1:0], col[1:0]};
   endfunction

   // Reference XY decision for a router at row 1, col 1.
   function automatic int xy_out(logic [31:0] p);
      int col;
      int row;
      col = int'(p[1:0]);
      row = int'(p[3:2]);
      if (col > 1) return 3;
      if (col < 1) return 4;
      if (row > 1) return 2;
      if (row < 1) return 1;
      return 0;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at the drive point (posedge+1); samples, updates the scoreboard, advances one cycle.
   task automatic tick();
      int          src;
      logic [31:0] want;
      #2;
      obs_vld  = out_vld;
      obs_rdy  = in_rdy;
      obs_pkt  = out_pkt;
      obs_drop = drop;
      if (!srst) chk("no_drop", drop, 0);
      for (int i = 0; i < NP; i++)
         if (in_vld[i] && in_rdy[i]) expq[xy_out(in_pkt[i]) * NP + i].push_back(in_pkt[i]);
      for (int o = 0; o < NP; o++) begin
         if (stall_prev[o]) begin
            chk("hold_valid", out_vld[o], 1);
            chk("hold_data", out_pkt[o], hold_pkt[o]);
         end
         if (out_vld[o] && out_rdy[o]) begin
            src  = int'(out_pkt[o][7:4]);
            want = 'x;
            if (src < NP && expq[o * NP + src].size() > 0) want = expq[o * NP + src].pop_front();
            chk("sb_order", out_pkt[o], want);
         end
         stall_prev[o] = (out_vld[o] === 1'b1) && (out_rdy[o] === 1'b0);
         hold_pkt[o]   = out_pkt[o];
      end
      if (srst) begin
         for (int j = 0; j < NP * NP; j++) expq[j].delete();
         stall_prev = '0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      srst   = 1'b1;
      in_vld = '0;
      tick();
      tick();
      srst   = 1'b0;
   endtask

   initial begin
      int k;
      int n;
      int rseq;
      srst    = 1'b0;
      in_vld  = '0;
      in_pkt  = '0;
      out_rdy = '1;
      #1;

      // Reset state
      reset_dut();
      tick();
      chk("rst_out_valid", obs_vld, 0);
      for (int o = 0; o < NP; o++) chk("rst_out_packet", obs_pkt[o], 0);
      chk("rst_in_ready", obs_rdy, 5'h1f);
      chk("rst_drop", obs_drop, 0);

      // Local delivery: NORTH -> LOCAL, two-cycle latency
      for (int c = 0; c < 4; c++) begin
         in_vld    = (c == 0) ? 5'b00010 : 5'b00000;
         in_pkt[1] = mk(1, 0, 1, 1);
         tick();
         if (c == 1) chk("local_early", obs_vld, 0);
         if (c == 2) begin
            chk("local_valid", obs_vld, 5'b00001);
            chk("local_data", obs_pkt[0], mk(1, 0, 1, 1));
         end
         if (c == 3) chk("local_done", obs_vld, 0);
      end

      // XY order from three inputs at once
      for (int c = 0; c < 3; c++) begin
         in_vld    = (c == 0) ? 5'b10101 : 5'b00000;
         in_pkt[0] = mk(0, 1, 3, 3);
         in_pkt[4] = mk(4, 1, 3, 1);
         in_pkt[2] = mk(2, 1, 0, 0);
         tick();
         if (c == 2) begin
            chk("xy_valid", obs_vld, 5'b11100);
            chk("xy_east", obs_pkt[3], mk(0, 1, 3, 3));
            chk("xy_south", obs_pkt[2], mk(4, 1, 3, 1));
            chk("xy_west", obs_pkt[4], mk(2, 1, 0, 0));
         end
      end

      // Round-robin contention on EAST
      reset_dut();
      for (int c = 0; c < 12; c++) begin
         in_vld = (c < 3) ? 5'b00111 : 5'b00000;
         for (int i = 0; i < 3; i++) in_pkt[i] = mk(i, c, 1, 3);
         tick();
         if (c >= 2 && c <= 10) begin
            chk("rr_valid", obs_vld[3], 1);
            chk("rr_src", obs_pkt[3][7:4], (c - 2) % 3);
            chk("rr_seq", obs_pkt[3][31:8], (c - 2) / 3);
         end
         if (c == 11) chk("rr_end", obs_vld[3], 0);
      end

      // Backpressure on EAST
      reset_dut();
      out_rdy = 5'b10111;
      k = 0;
      for (int c = 0; c < 12; c++) begin
         in_vld    = (k < 6) ? 5'b00001 : 5'b00000;
         in_pkt[0] = mk(0, k, 1, 3);
         tick();
         if (k < 6 && obs_rdy[0]) k++;
         if (c >= 2) begin
            chk("bp_hold_valid", obs_vld[3], 1);
            chk("bp_hold_first", obs_pkt[3], mk(0, 0, 1, 3));
         end
      end
      chk("bp_accepted", k, 5);
      chk("bp_ready_low", obs_rdy[0], 0);
      in_vld  = '0;
      out_rdy = '1;
      n = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (obs_vld[3]) begin
            chk("bp_release_order", obs_pkt[3], mk(0, n, 1, 3));
            n++;
         end
      end
      chk("bp_delivered", n, 5);

      // Reset while packets are buffered
      reset_dut();
      out_rdy = 5'b10111;
      for (int c = 0; c < 5; c++) begin
         in_vld    = (c < 3) ? 5'b00001 : 5'b00000;
         in_pkt[0] = mk(0, 20 + c, 1, 3);
         tick();
      end
      srst = 1'b1;
      tick();
      chk("mid_rst_ready_forced", obs_rdy, 0);
      srst    = 1'b0;
      out_rdy = '1;
      tick();
      chk("mid_rst_valid", obs_vld, 0);
      chk("mid_rst_ready", obs_rdy, 5'h1f);
      for (int c = 0; c < 8; c++) begin
         tick();
         chk("mid_rst_no_stale", obs_vld, 0);
      end

      // Throughput: EAST input to LOCAL, back-to-back
      for (int c = 0; c < 12; c++) begin
         in_vld    = (c < 8) ? 5'b01000 : 5'b00000;
         in_pkt[3] = mk(3, c, 1, 1);
         tick();
         if (c >= 2 && c <= 9) begin
            chk("tput_valid", obs_vld[0], 1);
            chk("tput_seq", obs_pkt[0], mk(3, c - 2, 1, 1));
         end
      end

      // Randomized traffic against the scoreboard
      rseq = 1000;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NP; i++) begin
            in_vld[i]  = 1'($urandom_range(0, 1));
            in_pkt[i]  = mk(i, rseq, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            out_rdy[i] = ($urandom_range(0, 3) != 0);
            rseq++;
         end
         tick();
      end
      in_vld  = '0;
      out_rdy = '1;
      for (int c = 0; c < 40; c++) tick();
      for (int j = 0; j < NP * NP; j++) chk("sb_drained", expq[j].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/noc_router_buffered.md
Name: noc_router_buffered

Overview:
- Second-generation mesh router for the APB-over-NoC fabric; replaces the combinational-merge, registered-output XY router.
- Five ports (LOCAL, NORTH, SOUTH, EAST, WEST), each with a parametrised input FIFO, a valid/ready handshake, and per-output round-robin arbitration.
- Packets follow dimension-ordered XY routing: column first, then row.
- One instance per mesh node. LOCAL connects to the node's network interface.

Parameters:
- GRID_WIDTH, 4, mesh is GRID_WIDTH x GRID_WIDTH, >=2.
- ROUTER_ROW, 0, this node's row, width COORD_WIDTH = $clog2(GRID_WIDTH).
- ROUTER_COL, 0, this node's column, width COORD_WIDTH.
- FIFO_DEPTH, 4, entries per input FIFO, power of two, >=2.
- PACKET_WIDTH, pa_noc::APB_PACKET_WIDTH, packet width (localparam).

Ports:
- i_clk  in  1  clock.
- i_srst  in  1  synchronous active-high reset; one clock, reset is synchronous and active-high.
- i_inPacket  in  [5][PACKET_WIDTH]  input packet per port, indexed by pa_noc::port_t.
- i_inValid  in  [5]  input packet valid.
- o_inReady  out  [5]  input FIFO can accept.
- o_outPacket  out  [5][PACKET_WIDTH]  output packet per port.
- o_outValid  out  [5]  output packet valid.
- i_outReady  in  [5]  downstream accepts.
- o_drop  out  1  one-cycle pulse when a head packet is discarded.

Behaviour:
- Port index: 0 LOCAL, 1 NORTH, 2 SOUTH, 3 EAST, 4 WEST.
- Destination fields:
  - dest col = packet[COORD_WIDTH-1:0].
  - dest row = packet[2*COORD_WIDTH-1:COORD_WIDTH].
- Reset (i_srst high at a clock edge):
  - All FIFOs emptied; o_outValid = 0 and o_outPacket = 0.
  - All arbiter pointers = 0; o_drop = 0.
  - o_inReady is forced to 0 while i_srst is high.
  - Reset mid-transfer discards all held packets; no partial state survives.
- Input side:
  - Push on i_inValid & o_inReady.
  - o_inReady = !full; no same-cycle bypass when full.
  - A push into an empty FIFO is visible at its head the next cycle.
- Route of the FIFO head, priority order:
  - dest col > ROUTER_COL -> EAST.
  - dest col < ROUTER_COL -> WEST.
  - dest row > ROUTER_ROW -> SOUTH.
  - dest row < ROUTER_ROW -> NORTH.
  - otherwise -> LOCAL.
- Out-of-mesh coordinates (only possible when GRID_WIDTH is not a power of two):
  - If the route would leave the mesh (EAST at col GRID_WIDTH-1, SOUTH at row GRID_WIDTH-1, or dest coordinate >= GRID_WIDTH), the head is popped without forwarding.
  - o_drop pulses for one cycle per discarded packet.
- Output side:
  - Each output has one register stage: valid + data.
  - The register loads when empty or draining (o_outValid & i_outReady) in the same cycle, giving one packet/cycle per output.
  - If o_outValid & !i_outReady, data is held stable and valid stays asserted until accepted.
- Arbitration (per output):
  - Round-robin among inputs whose head routes to that output.
  - Search starts at the pointer.
  - On a grant that loads the register, pointer <- granted index + 1, mod 5.
  - No grant means no pointer change.
  - The granted FIFO pops in the same cycle.
- Routing guarantees:
  - One input head routes to exactly one output, so there is no multi-grant per input.
  - Any input may route to any output, including back out of its own port; XY never generates that for legal traffic.
- Latency: input push at cycle N -> o_outValid at N+2, given an empty FIFO, no contention and a free output.
- Ordering: packets from one input to one output leave in arrival order.
- Full FIFO plus stalled output: backpressure propagates; o_inReady stays 0 until a pop occurs. Packets are never lost.
- Simultaneous push and pop on a full FIFO: the pop proceeds; the push is refused because o_inReady is 0 that cycle.

Decomposition:
- pa_noc additions:
  - port_t enum (LOCAL, NORTH, SOUTH, EAST, WEST).
  - N_PORTS = 5.
  - Function coord_lsb(field) returning the bit positions of row/col.
  - Existing APB_PACKET_WIDTH.
- Sub-module noc_fifo:
  - Parameters DEPTH, WIDTH.
  - Synchronous active-high reset.
  - Ports: push/pop, full/empty, head data.
  - Instantiated five times.
- Round-robin arbiter and route decode stay inline in generate loops.

Test Plan (GRID_WIDTH=4, router at row 1, col 1, FIFO_DEPTH=4; low nibble = {row,col}):
- Local delivery: packet 0x...5 (row 1, col 1) on NORTH at cycle 0 -> o_outValid[LOCAL] = 1 at cycle 2 with identical data; nothing on other outputs.
- XY order: packet with row 3, col 3 (0x...F) on LOCAL -> leaves EAST. Packet with row 3, col 1 (0x...D) on WEST -> leaves SOUTH. Packet with row 0, col 0 (0x...0) -> leaves WEST.
- Round-robin contention: NORTH, SOUTH and LOCAL each stream 3 packets to EAST from the same cycle, i_outReady[EAST] = 1 -> grant order LOCAL, NORTH, SOUTH repeating; 9 packets in 9 consecutive cycles.
- Backpressure: i_outReady[EAST] = 0, push 6 EAST-bound packets on LOCAL:
  - o_outValid[EAST] held with the first packet.
  - o_inReady[LOCAL] drops after 5 accepted: 4 FIFO entries + 1 output register.
  - Release -> all 5 delivered in order.
- Reset mid-operation: assert i_srst for 1 cycle while 3 packets are buffered -> next cycle all o_outValid = 0, o_inReady = 1; no stale packet ever emerges.
- Throughput: back-to-back packets on EAST input to LOCAL with ready held high -> one output per cycle, no bubbles, o_drop never asserts.
